// File: rtl/axi4_write_arbiter_pkg.sv
// Shared widths, AXI4 field encodings and arbiter state encoding for the
// 2:1 AXI4 write-channel arbiter.
package axi4_write_arbiter_pkg;

   localparam int ADDRESS_WIDTH     = 16;
   localparam int DATA_WIDTH        = 32;
   localparam int STROBE_WIDTH      = DATA_WIDTH / 8;
   localparam int ID_WIDTH          = 4;
   localparam int LENGTH            = 8;
   localparam int NO_OF_ARB_MASTERS = 2;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } awburst_e;

   typedef enum logic [2:0] {
      SIZE_1B   = 3'b000,
      SIZE_2B   = 3'b001,
      SIZE_4B   = 3'b010,
      SIZE_8B   = 3'b011,
      SIZE_16B  = 3'b100,
      SIZE_32B  = 3'b101,
      SIZE_64B  = 3'b110,
      SIZE_128B = 3'b111
   } awsize_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } bresp_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10,
      RESP = 2'b11
   } arb_state_e;

endpackage

// File: rtl/axi4_rr_grant.sv
// Two-requester round-robin picker: one-hot grant from the request vector and
// a priority pointer that moves to the other master on each release pulse.
module axi4_rr_grant (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic [1:0] req,
   input  logic       rel,
   input  logic       owner,
   output logic [1:0] grant
);

   logic rr_ptr_r;

   // Pointer only breaks ties; a lone requester always wins.
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = rr_ptr_r ? 2'b10 : 2'b01;
      end else begin
         grant = req;
      end
   end

   // Priority pointer update on release of the current owner.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rr_ptr_r <= 1'b0;
      end else if (rel) begin
         rr_ptr_r <= ~owner;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

endmodule

// File: rtl/axi4_write_arbiter.sv
// 2:1 AXI4 write arbiter, one outstanding write, grant held from AW to B.
// Optional WLAST regeneration/check: define AXI4_WRITE_ARB_WLAST_CHECK_EN.
module axi4_write_arbiter #(
   parameter int ADDRESS_WIDTH = axi4_write_arbiter_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = axi4_write_arbiter_pkg::DATA_WIDTH,
   parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
   parameter int ID_WIDTH      = axi4_write_arbiter_pkg::ID_WIDTH,
   parameter int LENGTH        = axi4_write_arbiter_pkg::LENGTH,
   localparam int NM           = axi4_write_arbiter_pkg::NO_OF_ARB_MASTERS,
   localparam int AW_W         = ID_WIDTH + ADDRESS_WIDTH + LENGTH + 3 + 2,
   localparam int W_W          = DATA_WIDTH + STROBE_WIDTH + 1,
   localparam int B_W          = ID_WIDTH + 2
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NM-1:0]            m_awvalid,
   output logic [NM-1:0]            m_awready,
   input  logic [NM-1:0][AW_W-1:0]  m_aw_payload,
   input  logic [NM-1:0]            m_wvalid,
   output logic [NM-1:0]            m_wready,
   input  logic [NM-1:0][W_W-1:0]   m_w_payload,
   output logic [NM-1:0]            m_bvalid,
   input  logic [NM-1:0]            m_bready,
   output logic [B_W-1:0]           m_b_payload,
   output logic                     s_awvalid,
   input  logic                     s_awready,
   output logic [AW_W-1:0]          s_aw_payload,
   output logic                     s_wvalid,
   input  logic                     s_wready,
   output logic [W_W-1:0]           s_w_payload,
   input  logic                     s_bvalid,
   output logic                     s_bready,
   input  logic [B_W-1:0]           s_b_payload,
   output logic [NM-1:0]            grant,
   output logic                     err_wlast
);

   import axi4_write_arbiter_pkg::*;

   arb_state_e        state_r;
   logic [NM-1:0]     grant_r;
   logic [LENGTH-1:0] beat_cnt_r;
   logic [NM-1:0]     rr_grant_s;
   logic              gidx_s;
   logic              aw_hs_s;
   logic              w_hs_s;
   logic              b_hs_s;
   logic              last_beat_s;
   logic              m_wlast_s;
   logic              s_wlast_s;
   logic [LENGTH-1:0] awlen_s;

   axi4_rr_grant u_rr_grant (
      .aclk    (aclk),
      .aresetn (aresetn),
      .req     (m_awvalid),
      .rel     (b_hs_s),
      .owner   (gidx_s),
      .grant   (rr_grant_s)
   );

   assign gidx_s      = grant_r[1];
   assign awlen_s     = m_aw_payload[gidx_s][LENGTH+4:5];
   assign m_wlast_s   = m_w_payload[gidx_s][0];
   assign last_beat_s = (beat_cnt_r == {LENGTH{1'b0}});

   // Channel muxes are qualified by state so nothing leaks outside its phase.
   assign s_awvalid    = (state_r == ADDR) & m_awvalid[gidx_s];
   assign m_awready    = (state_r == ADDR) ? (grant_r & {NM{s_awready}}) : {NM{1'b0}};
   assign s_aw_payload = m_aw_payload[gidx_s];
   assign s_wvalid     = (state_r == DATA) & m_wvalid[gidx_s];
   assign m_wready     = (state_r == DATA) ? (grant_r & {NM{s_wready}}) : {NM{1'b0}};
   assign s_w_payload  = {m_w_payload[gidx_s][W_W-1:1], s_wlast_s};
   assign m_bvalid     = (state_r == RESP) ? (grant_r & {NM{s_bvalid}}) : {NM{1'b0}};
   assign s_bready     = (state_r == RESP) & m_bready[gidx_s];
   assign m_b_payload  = s_b_payload;
   assign grant        = grant_r;

   assign aw_hs_s = s_awvalid & s_awready;
   assign w_hs_s  = s_wvalid & s_wready;
   assign b_hs_s  = s_bvalid & s_bready;

   // Arbitration FSM: grant taken in IDLE, released on the B handshake.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r    <= IDLE;
         grant_r    <= {NM{1'b0}};
         beat_cnt_r <= {LENGTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (|m_awvalid) begin
                  grant_r <= rr_grant_s;
                  state_r <= ADDR;
               end
            end
            ADDR: begin
               if (aw_hs_s) begin
                  beat_cnt_r <= awlen_s;
                  state_r    <= DATA;
               end
            end
            DATA: begin
               if (w_hs_s) begin
                  if (last_beat_s) begin
                     state_r <= RESP;
                  end else begin
                     beat_cnt_r <= beat_cnt_r - LENGTH'(1);
                  end
               end
            end
            RESP: begin
               if (b_hs_s) begin
                  grant_r <= {NM{1'b0}};
                  state_r <= IDLE;
               end
            end
            default: begin
               grant_r <= {NM{1'b0}};
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef AXI4_WRITE_ARB_WLAST_CHECK_EN
   logic err_wlast_r;

   // Burst end comes from the beat counter; master wlast is only checked.
   assign s_wlast_s = last_beat_s;
   assign err_wlast = err_wlast_r;

   // One-cycle flag for any accepted beat whose wlast disagrees with the count.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_wlast_r <= 1'b0;
      end else begin
         err_wlast_r <= w_hs_s & (m_wlast_s != last_beat_s);
      end
   end
`else
   assign s_wlast_s = m_wlast_s;
   assign err_wlast = 1'b0;
`endif

endmodule

// File: doc/axi4_write_arbiter.md
Name: axi4_write_arbiter

Overview:
- 2:1 AXI4 write-channel arbiter.
- Two master ports share one slave's AW, W and B channels.
- Round-robin grant, held from AW acceptance until the B handshake completes, so at most one write is outstanding.
- Sits between the master-side write drivers and the single slave write interface (ADDRESS_WIDTH=16, DATA_WIDTH=32 system).

Parameters:
- ADDRESS_WIDTH, 16, AWADDR width.
- DATA_WIDTH, 32, WDATA width.
- STROBE_WIDTH, DATA_WIDTH/8, WSTRB width.
- ID_WIDTH, 4, AWID/BID width.
- LENGTH, 8, AWLEN width.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- m_awvalid  in  2  per-master AW valid; bit i = master i.
- m_awready  out  2  per-master AW ready.
- m_aw_payload  in  2x(ID_WIDTH+ADDRESS_WIDTH+LENGTH+3+2)  per-master {awid,awaddr,awlen,awsize,awburst}.
- m_wvalid  in  2  per-master W valid.
- m_wready  out  2  per-master W ready.
- m_w_payload  in  2x(DATA_WIDTH+STROBE_WIDTH+1)  per-master {wdata,wstrb,wlast}.
- m_bvalid  out  2  per-master B valid.
- m_bready  in  2  per-master B ready.
- m_b_payload  out  ID_WIDTH+2  {bid,bresp}, common to both masters, qualified by m_bvalid.
- s_awvalid/s_awready  out/in  1/1  slave AW handshake.
- s_aw_payload  out  ID_WIDTH+ADDRESS_WIDTH+LENGTH+3+2  granted AW fields.
- s_wvalid/s_wready  out/in  1/1  slave W handshake.
- s_w_payload  out  DATA_WIDTH+STROBE_WIDTH+1  granted W fields.
- s_bvalid/s_bready  in/out  1/1  slave B handshake.
- s_b_payload  in  ID_WIDTH+2  slave {bid,bresp}.
- grant  out  2  one-hot current owner; 00 in IDLE.
- err_wlast  out  1  WLAST mismatch pulse (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert by the driving environment):
  - state=IDLE, grant=00, rr_ptr=master 0, beat_cnt=0.
  - Every valid/ready output = 0; err_wlast = 0.
  - Assertion mid-burst aborts the transaction immediately; no partial-state recovery.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any m_awvalid is set, register grant next edge. If both are set, the master at rr_ptr wins.
  - Go to ADDR.
  - Latency: 1 cycle from m_awvalid to s_awvalid.
- ADDR:
  - s_awvalid = m_awvalid[g]; m_awready[g] = s_awready; s_aw_payload = granted payload.
  - On the s_awvalid & s_awready edge: latch awlen into beat_cnt, go to DATA.
  - Non-granted ready signals are held 0.
- DATA:
  - W mux combinational from the granted master. Each s_wvalid & s_wready beat decrements beat_cnt.
  - Beat with beat_cnt==0 is the final beat: go to RESP. awlen=0 means a single beat.
  - Data is never accepted from the non-granted master.
  - W before AW from the granted master is not supported; m_wready stays 0 until DATA.
- RESP:
  - m_bvalid[g] = s_bvalid; s_bready = m_bready[g]; m_b_payload = s_b_payload.
  - On the B handshake: rr_ptr = other master, grant = 00, go to IDLE.
- Back-to-back: a new grant is earliest on the cycle after IDLE is re-entered. Minimum 2 idle cycles between slave AW handshakes.
- The arbiter does not interpret awburst or awsize; both are passed through unchanged.

Optional Feature:
- Macro: AXI4_WRITE_ARB_WLAST_CHECK_EN.
- Defined:
  - s_wlast is generated from beat_cnt==0, not forwarded.
  - err_wlast pulses 1 cycle on any accepted beat where the master wlast != (beat_cnt==0).
  - An early wlast does not end the burst.
- Undefined:
  - s_wlast = granted master wlast; err_wlast tied 0.
  - The DATA exit condition is still beat_cnt==0.

Decomposition:
- Shared package holds:
  - ADDRESS_WIDTH, DATA_WIDTH, STROBE_WIDTH, LENGTH.
  - awburst_e, awsize_e, bresp_e.
  - New enum arb_state_e {IDLE,ADDR,DATA,RESP}.
  - New constant NO_OF_ARB_MASTERS=2.
- Sub-module axi4_rr_grant: request vector + rr_ptr -> one-hot grant, plus pointer update on a release pulse.

Test Plan:
- Master0 only, awaddr=16'h0100, awlen=3, INCR, 4-byte: 4 beats forwarded, bresp=OKAY to master0; grant returns 00; rr_ptr=1.
- Both m_awvalid in the same cycle after reset: master0 granted first, master1's full burst follows; slave AW order is 0 then 1.
- awlen=0 from master1 with s_wready low for 5 cycles: m_wready[1] tracks s_wready; exactly one beat; master0 sees no valid/ready.
- Slave returns bresp=SLVERR with bid=4'h7: routed to the owning master only; the other m_bvalid stays 0.
- aresetn low during DATA beat 2 of 8: all outputs 0 asynchronously; after release, a new transaction completes normally.
- With the macro defined, awlen=3 and master asserting wlast on beat 1: err_wlast pulses once; s_wlast only on beat 3; burst completes with 4 beats.
